// File: rtl/alu_pkg.sv
// Shared opcode encoding and flag-update policy for the datapath ALU.
package alu_pkg;

   typedef enum logic [2:0] {
      OP_MOV = 3'b000,
      OP_CMP = 3'b001,
      OP_ADD = 3'b010,
      OP_SUB = 3'b011,
      OP_NEG = 3'b100,
      OP_SHF = 3'b101,
      OP_LOG = 3'b110,
      OP_RSV = 3'b111
   } aluop_t;

   localparam int unsigned DATA_W = 8;

   // Only arithmetic ops update the branch flags.
   function automatic logic sets_flags(input aluop_t op);
      logic hit;
      hit = 1'b0;
      case (op)
         OP_CMP, OP_ADD, OP_SUB, OP_NEG: hit = 1'b1;
         default:                        hit = 1'b0;
      endcase
      return hit;
   endfunction

endpackage

// File: rtl/alu_shifter.sv
// Logical shifter, zero fill; the full 8-bit amount is honoured, so >= 8 gives 0.
module alu_shifter
   import alu_pkg::*;
(
   input  logic [DATA_W-1:0] data_i,
   input  logic [DATA_W-1:0] amt_i,
   input  logic              lsr_i,
   output logic [DATA_W-1:0] shf_o
);

   always_comb begin
      shf_o = '0;
      if (amt_i[7:3] == 5'd0) begin
         if (lsr_i) shf_o = data_i >> amt_i[2:0];
         else       shf_o = data_i << amt_i[2:0];
      end
   end

endmodule

// File: rtl/alu.sv
// 8-bit datapath ALU: combinational result with Zero/Neg, plus a flag pair
// registered from arithmetic ops for later conditional branches.
module alu
   import alu_pkg::*;
(
   input  logic       clk,
   input  logic       rst_n,
   input  logic [2:0] Aluop,
   input  logic [7:0] DatA,
   input  logic [7:0] DatB,
   input  logic       LSL_sel,
   input  logic       ORR_sel,
   output logic [7:0] Rslt,
   output logic       Zero,
   output logic       Neg,
   output logic       ZeroFlag,
   output logic       NegFlag
);

   aluop_t     op;
   logic [7:0] shf_val;
   logic [7:0] rslt_d;
   logic       zero_flag_q, zero_flag_d;
   logic       neg_flag_q,  neg_flag_d;

   assign op = aluop_t'(Aluop);

   alu_shifter u_shifter (
      .data_i (DatA),
      .amt_i  (DatB),
      .lsr_i  (LSL_sel),
      .shf_o  (shf_val)
   );

   always_comb begin
      rslt_d = 8'h00;
      case (op)
         OP_MOV:  rslt_d = DatB;
         OP_CMP:  rslt_d = DatA - DatB;
         OP_ADD:  rslt_d = DatA + DatB;
         OP_SUB:  rslt_d = DatA - DatB;
         OP_NEG:  rslt_d = 8'h00 - DatA;
         OP_SHF:  rslt_d = shf_val;
         OP_LOG:  rslt_d = ORR_sel ? (DatA | DatB) : (DatA & DatB);
         default: rslt_d = 8'h00;
      endcase
   end

   assign Rslt = rslt_d;
   assign Zero = (rslt_d == 8'h00);
   assign Neg  = rslt_d[7];

   always_comb begin
      zero_flag_d = zero_flag_q;
      neg_flag_d  = neg_flag_q;
      if (sets_flags(op)) begin
         zero_flag_d = Zero;
         neg_flag_d  = Neg;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         zero_flag_q <= 1'b0;
         neg_flag_q  <= 1'b0;
      end else begin
         zero_flag_q <= zero_flag_d;
         neg_flag_q  <= neg_flag_d;
      end
   end

   assign ZeroFlag = zero_flag_q;
   assign NegFlag  = neg_flag_q;

endmodule

// File: tb/tb_alu.sv
// Directed self-checking bench for alu: hand-computed vectors, immediate assertions.
module tb_alu;

   logic       clk;
   logic       rst_n;
   logic [2:0] Aluop;
   logic [7:0] DatA;
   logic [7:0] DatB;
   logic       LSL_sel;
   logic       ORR_sel;
   logic [7:0] Rslt;
   logic       Zero;
   logic       Neg;
   logic       ZeroFlag;
   logic       NegFlag;

   int checks = 0;
   int errors = 0;

   alu dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .Aluop    (Aluop),
      .DatA     (DatA),
      .DatB     (DatB),
      .LSL_sel  (LSL_sel),
      .ORR_sel  (ORR_sel),
      .Rslt     (Rslt),
      .Zero     (Zero),
      .Neg      (Neg),
      .ZeroFlag (ZeroFlag),
      .NegFlag  (NegFlag)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic apply(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b,
                        input logic lsl, input logic orr);
      @(negedge clk);
      Aluop = op; DatA = a; DatB = b; LSL_sel = lsl; ORR_sel = orr;
      #1;
   endtask

   task automatic chk_res(input string tag, input logic [7:0] r, input logic z, input logic n);
      chk({tag, ".rslt"}, Rslt, r);
      chk({tag, ".zero"}, {7'd0, Zero}, {7'd0, z});
      chk({tag, ".neg"},  {7'd0, Neg},  {7'd0, n});
   endtask

   task automatic chk_flags(input string tag, input logic z, input logic n);
      @(posedge clk);
      #1;
      chk({tag, ".zflag"}, {7'd0, ZeroFlag}, {7'd0, z});
      chk({tag, ".nflag"}, {7'd0, NegFlag},  {7'd0, n});
   endtask

   initial begin
      rst_n = 1'b0; Aluop = 3'b000; DatA = 8'd0; DatB = 8'd0; LSL_sel = 1'b0; ORR_sel = 1'b0;
      #12;
      chk("reset.zflag", {7'd0, ZeroFlag}, 8'd0);
      chk("reset.nflag", {7'd0, NegFlag},  8'd0);
      @(negedge clk);
      rst_n = 1'b1;

      apply(3'b000, 8'd0, 8'd15, 1'b0, 1'b0);   chk_res("mov15", 8'd15, 1'b0, 1'b0);
      chk_flags("mov15", 1'b0, 1'b0);
      apply(3'b001, 8'd20, 8'd20, 1'b0, 1'b0);  chk_res("cmp_eq", 8'd0, 1'b1, 1'b0);
      chk_flags("cmp_eq", 1'b1, 1'b0);
      apply(3'b010, 8'd10, 8'd5, 1'b0, 1'b0);   chk_res("add", 8'd15, 1'b0, 1'b0);
      chk_flags("add", 1'b0, 1'b0);
      apply(3'b011, 8'd15, 8'd5, 1'b0, 1'b0);   chk_res("sub", 8'd10, 1'b0, 1'b0);
      apply(3'b011, 8'd5, 8'd15, 1'b0, 1'b0);   chk_res("sub_neg", 8'd246, 1'b0, 1'b1);
      chk_flags("sub_neg", 1'b0, 1'b1);
      apply(3'b010, 8'd200, 8'd100, 1'b0, 1'b0); chk_res("add_wrap", 8'd44, 1'b0, 1'b0);
      chk_flags("add_wrap", 1'b0, 1'b0);
      apply(3'b100, 8'd10, 8'd77, 1'b0, 1'b0);  chk_res("neg", 8'd246, 1'b0, 1'b1);
      chk_flags("neg", 1'b0, 1'b1);
      apply(3'b000, 8'd0, 8'd0, 1'b0, 1'b0);    chk_res("mov0", 8'd0, 1'b1, 1'b0);
      chk_flags("mov0_hold", 1'b0, 1'b1);

      apply(3'b101, 8'd4, 8'd2, 1'b0, 1'b1);    chk_res("lsl", 8'd16, 1'b0, 1'b0);
      apply(3'b101, 8'd16, 8'd1, 1'b1, 1'b0);   chk_res("lsr", 8'd8, 1'b0, 1'b0);
      apply(3'b101, 8'd255, 8'd7, 1'b0, 1'b0);  chk_res("lsl7", 8'h80, 1'b0, 1'b1);
      apply(3'b101, 8'd1, 8'd8, 1'b0, 1'b0);    chk_res("lsl8", 8'd0, 1'b1, 1'b0);
      apply(3'b101, 8'd255, 8'd200, 1'b1, 1'b0); chk_res("lsr200", 8'd0, 1'b1, 1'b0);
      chk_flags("shf_hold", 1'b0, 1'b1);

      apply(3'b110, 8'b10101010, 8'b11001100, 1'b1, 1'b0); chk_res("and", 8'b10001000, 1'b0, 1'b1);
      apply(3'b110, 8'b10101010, 8'b11001100, 1'b0, 1'b1); chk_res("orr", 8'b11101110, 1'b0, 1'b1);
      apply(3'b111, 8'hA5, 8'h5A, 1'b1, 1'b1);  chk_res("rsv", 8'd0, 1'b1, 1'b0);
      chk_flags("log_rsv_hold", 1'b0, 1'b1);

      apply(3'b001, 8'd1, 8'd1, 1'b0, 1'b0);    chk_res("cmp11", 8'd0, 1'b1, 1'b0);
      chk_flags("cmp11", 1'b1, 1'b0);
      Aluop = 3'b000; DatB = 8'h55;
      #1;
      rst_n = 1'b0;
      #1;
      chk("rstpulse.zflag", {7'd0, ZeroFlag}, 8'd0);
      chk("rstpulse.nflag", {7'd0, NegFlag},  8'd0);
      chk("rstpulse.rslt", Rslt, 8'h55);
      Aluop = 3'b111;
      #1;
      chk("rstpulse.rsv", Rslt, 8'h00);
      rst_n = 1'b1;

      apply(3'b001, 8'd3, 8'd5, 1'b0, 1'b0);    chk_res("cmp35", 8'd254, 1'b0, 1'b1);
      chk_flags("post_reset", 1'b0, 1'b1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
